matrix_stream_flattener: RTL and testbench
==========================================

# matrix_stream_flattener

Sequential, parametrised successor to the combinational matrix flattener. Captures a HEIGHT×WIDTH matrix of signed P-bit elements in one valid/ready handshake, then streams it out as fixed-width beats of BEAT_ELEMS elements each. Supports row-major or column-major (transposed) ordering, selected per matrix. Sits between a matrix-producing compute stage and a narrow streaming bus or memory writer.

## Interface
- WIDTH, 8, matrix columns
- HEIGHT, 4, matrix rows
- P, 8, element width in bits
- BEAT_ELEMS, 4, elements per output beat; must divide WIDTH*HEIGHT (elaboration-time assertion)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- a_i  in  signed [P-1:0] [HEIGHT][WIDTH]  input matrix
- col_major_i  in  1  ordering for this matrix (1 = column-major); sampled with the input handshake
- in_valid_i  in  1  matrix valid
- in_ready_o  out  1  block can accept a matrix
- data_o  out  BEAT_ELEMS*P  current output beat
- out_valid_o  out  1  beat valid
- out_ready_i  in  1  downstream accepts beat
- last_o  out  1  current beat is the final beat of the matrix

## Operation
- NBEATS = WIDTH*HEIGHT/BEAT_ELEMS. Beat counter width = max(1, $clog2(NBEATS)).
- Element stream index k = 0..WIDTH*HEIGHT-1. Row-major: k → A[k / WIDTH][k % WIDTH]. Column-major: k → A[k % HEIGHT][k / HEIGHT].
- Beat b carries k = b*BEAT_ELEMS + e for e = 0..BEAT_ELEMS-1. Element e occupies data_o[(BEAT_ELEMS-e)*P-1 -: P]: first element at the MSBs. The same MSB-first packing as the flat bus.
- States:
  - IDLE: in_ready_o = 1, out_valid_o = 0. On in_valid_i && in_ready_o, register a_i and col_major_i, clear the beat counter, and go to STREAM.
  - STREAM: out_valid_o = 1. On out_valid_o && out_ready_i, increment the counter. On the last-beat handshake, go to IDLE.
- Back-to-back accept: in_ready_o is also 1 in STREAM during the cycle in which the last beat handshakes. If in_valid_i is high in that cycle, load the new matrix, reset the counter, and stay in STREAM. There is no bubble between matrices.
- last_o = (state == STREAM) && (counter == NBEATS-1).
- data_o and last_o are don't-care while out_valid_o = 0, but they must not be X in simulation.
- The stored matrix and mode hold stable while out_valid_o && !out_ready_i (standard AXI-S stability).

## Timing
- Reset (async assert, sync release): state = IDLE, counter = 0, out_valid_o = 0, last_o = 0, in_ready_o = 1, data_o = 0, stored matrix = 0.
- Latency: the first beat is valid in the cycle after input acceptance.
- Throughput: one beat per cycle under continuous out_ready_i. One matrix per NBEATS cycles with no gaps.
- data_o is combinational from the registered matrix, mode and counter. There is no combinational path from in_valid_i or out_ready_i to data_o.
- in_ready_o depends combinationally on out_ready_i (last-beat overlap only).
- Reset mid-stream discards the matrix immediately. The next beat needs a fresh input handshake.
- NBEATS = 1: every beat is last, and a matrix can be accepted every cycle.

## Configuration
- MATRIX_STREAM_FLATTENER_TRANSPOSE_EN defined: col_major_i is sampled and column-major ordering is supported.
- Macro undefined: col_major_i is ignored, and the stored mode and column-major index logic are removed. Output is always row-major.

## Structure
- Package matrix_stream_pkg holds:
  - state_t enum {IDLE, STREAM}
  - function nbeats(width, height, beat_elems)
  - function elem_index(k, col_major, width, height), returning the row/col pair
- Sub-module matrix_beat_select is combinational: it takes the stored matrix, beat index and mode, and produces data_o. The top module holds the FSM, counter and registers.

## Test plan
- Fill with A[i][j] = i*WIDTH+j, row-major, out_ready_i held 1 → 8 beats. Beat 0 = 0x00010203. Beat 7 = 0x1C1D1E1F with last_o = 1. in_ready_o = 1 on the beat-7 cycle.
- Same matrix with col_major_i = 1 (macro defined) → beat 0 = 0x00081018, beat 1 = 0x01091119, beat 7 = 0x070F171F.
- Same stimulus with the macro undefined → output is identical to the row-major case.
- out_ready_i low for 3 cycles on beat 2 → data_o and last_o hold 0x08090A0B, and the counter does not advance.
- Second matrix presented during the final beat of the first → accepted that cycle. Its beat 0 follows the first matrix's beat 7 with no idle cycle.
- rst_ni pulsed low mid-beat 4 → out_valid_o = 0 and in_ready_o = 1 immediately, with no further beats. A new matrix restarts at beat 0.

Source files
------------

// File: rtl/matrix_stream_flattener_pkg.sv
// Shared types and index helpers for the matrix stream flattener.
package matrix_stream_pkg;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  typedef struct packed {
    int row;
    int col;
  } rc_t;

  function automatic int nbeats(input int width, input int height, input int beat_elems);
    return (width * height) / beat_elems;
  endfunction

  // Maps stream position k to the matrix coordinate it carries.
  function automatic rc_t elem_index(input int k, input logic col_major,
                                     input int width, input int height);
    rc_t rc;
    if (col_major) begin
      rc.row = k % height;
      rc.col = k / height;
    end else begin
      rc.row = k / width;
      rc.col = k % width;
    end
    return rc;
  endfunction

endpackage

// File: rtl/matrix_stream_flattener_if.sv
// Matrix-in / beat-out handshake bundle; slave is the flattener, master the environment.
interface matrix_stream_flattener_if #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 4,
  parameter int P          = 8,
  parameter int BEAT_ELEMS = 4
);
  logic signed [HEIGHT-1:0][WIDTH-1:0][P-1:0] a_i;
  logic                                       col_major_i;
  logic                                       in_valid_i;
  logic                                       in_ready_o;
  logic [BEAT_ELEMS*P-1:0]                    data_o;
  logic                                       out_valid_o;
  logic                                       out_ready_i;
  logic                                       last_o;

  modport slave (
    input  a_i, col_major_i, in_valid_i, out_ready_i,
    output in_ready_o, data_o, out_valid_o, last_o
  );

  modport master (
    output a_i, col_major_i, in_valid_i, out_ready_i,
    input  in_ready_o, data_o, out_valid_o, last_o
  );
endinterface

// File: rtl/matrix_beat_select.sv
// Combinational beat extractor: picks BEAT_ELEMS elements of the stored matrix, first at the MSBs.
module matrix_beat_select
  import matrix_stream_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 4,
  parameter int P          = 8,
  parameter int BEAT_ELEMS = 4,
  parameter int CW         = 3
) (
  input  logic [HEIGHT-1:0][WIDTH-1:0][P-1:0] mat,
  input  logic [CW-1:0]                       beat,
  input  logic                                col_major,
  output logic [BEAT_ELEMS*P-1:0]             data
);

  rc_t rc;

  // Constant-index compare tree keeps the mux free of out-of-range reads.
  always_comb begin
    data = '0;
    rc   = '0;
    for (int e = 0; e < BEAT_ELEMS; e++) begin
      rc = elem_index((int'(beat) * BEAT_ELEMS + e) % (WIDTH * HEIGHT), col_major, WIDTH, HEIGHT);
      for (int r = 0; r < HEIGHT; r++)
        for (int c = 0; c < WIDTH; c++)
          if (rc.row == r && rc.col == c)
            data[(BEAT_ELEMS-e)*P-1 -: P] = mat[r][c];
    end
  end

endmodule

// File: rtl/matrix_stream_flattener.sv
// Captures a matrix in one handshake and streams it as BEAT_ELEMS-wide beats.
// Define MATRIX_STREAM_FLATTENER_TRANSPOSE_EN to enable per-matrix column-major ordering.
module matrix_stream_flattener
  import matrix_stream_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 4,
  parameter int P          = 8,
  parameter int BEAT_ELEMS = 4
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  matrix_stream_flattener_if.slave bus
);

  localparam int NBEATS = nbeats(WIDTH, HEIGHT, BEAT_ELEMS);
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  if ((WIDTH * HEIGHT) % BEAT_ELEMS != 0) begin : g_bad_beat
    $error("BEAT_ELEMS must divide WIDTH*HEIGHT");
  end

  state_t                             state_q, state_d;
  logic [CW-1:0]                      cnt_q;
  logic [HEIGHT-1:0][WIDTH-1:0][P-1:0] mat_q;
  logic                               mode_q;
  logic                               is_last, out_hs, accept;

  assign is_last        = (state_q == STREAM) && (cnt_q == CW'(NBEATS - 1));
  assign out_hs         = (state_q == STREAM) && bus.out_ready_i;
  // Ready overlaps the final beat so consecutive matrices stream without a bubble.
  assign bus.in_ready_o = (state_q == IDLE) || (is_last && bus.out_ready_i);
  assign accept         = bus.in_valid_i && bus.in_ready_o;

  assign bus.out_valid_o = (state_q == STREAM);
  assign bus.last_o      = is_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = STREAM;
      STREAM:  if (out_hs && is_last) state_d = accept ? STREAM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
        mat_q <= bus.a_i;
      end else if (out_hs) begin
        cnt_q <= is_last ? '0 : cnt_q + 1'b1;
      end
    end
  end

`ifdef MATRIX_STREAM_FLATTENER_TRANSPOSE_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     mode_q <= 1'b0;
    else if (accept) mode_q <= bus.col_major_i;
  end
`else
  assign mode_q = 1'b0;
`endif

  matrix_beat_select #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .P(P), .BEAT_ELEMS(BEAT_ELEMS), .CW(CW)
  ) u_sel (
    .mat      (mat_q),
    .beat     (cnt_q),
    .col_major(mode_q),
    .data     (bus.data_o)
  );

endmodule

// File: tb/tb_matrix_stream_flattener.sv
// Directed bench with a queue-based reference model checked on every negedge.
module tb_matrix_stream_flattener;
  localparam int W = 8, H = 4, P = 8, BE = 4;
  localparam int NB = W * H / BE;
  typedef logic [H-1:0][W-1:0][P-1:0] mat_t;

  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;
  logic [BE*P-1:0] exp_q[$];
  logic            exp_last_q[$];

  matrix_stream_flattener_if #(.WIDTH(W), .HEIGHT(H), .P(P), .BEAT_ELEMS(BE)) bus ();
  matrix_stream_flattener #(.WIDTH(W), .HEIGHT(H), .P(P), .BEAT_ELEMS(BE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beat b of matrix m, straight from the ordering rules.
  function automatic logic [BE*P-1:0] model_beat(input mat_t m, input logic cm, input int b);
    logic [BE*P-1:0] v = '0;
    for (int e = 0; e < BE; e++) begin
      int k = b * BE + e;
      int r = cm ? k % H : k / W;
      int c = cm ? k / H : k % W;
      v = (v << P) | (BE*P)'(m[r][c]);
    end
    return v;
  endfunction

  function automatic mat_t fill(input int base);
    mat_t m;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        m[i][j] = P'(base + i * W + j);
    return m;
  endfunction

  // Scoreboard: pops on beat handshake, then pushes beats of a newly accepted matrix.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); exp_last_q.delete();
    end else begin
      check("valid_vs_model", bus.out_valid_o, exp_q.size() != 0);
      if (bus.out_valid_o && exp_q.size() != 0) begin
        check("data_vs_model", bus.data_o, exp_q[0]);
        check("last_vs_model", bus.last_o, exp_last_q[0]);
        if (bus.out_ready_i) begin
          void'(exp_q.pop_front()); void'(exp_last_q.pop_front());
        end
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        logic cm;
`ifdef MATRIX_STREAM_FLATTENER_TRANSPOSE_EN
        cm = bus.col_major_i;
`else
        cm = 1'b0;
`endif
        for (int b = 0; b < NB; b++) begin
          exp_q.push_back(model_beat(bus.a_i, cm, b));
          exp_last_q.push_back(b == NB - 1);
        end
      end
    end
  end

  task automatic send(input mat_t m, input logic cm);
    int n = 0;
    bus.a_i = m; bus.col_major_i = cm; bus.in_valid_i = 1'b1;
    @(negedge clk);
    while (!bus.in_ready_o && n < 20) begin n++; @(negedge clk); end
    if (n >= 20) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic step(); @(posedge clk); #1; endtask

  initial begin
    mat_t m0 = fill(0);
    bus.a_i = '0; bus.col_major_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    #12;
    check("rst_valid", bus.out_valid_o, 1'b0);
    check("rst_ready", bus.in_ready_o, 1'b1);
    check("rst_data", bus.data_o, 0);
    check("rst_last", bus.last_o, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    check("model_b0", model_beat(m0, 1'b0, 0), 32'h00010203);
    check("model_cm_b1", model_beat(m0, 1'b1, 1), 32'h01091119);

    // Row-major, continuous ready
    send(m0, 1'b0);
    for (int b = 0; b < NB; b++) begin
      @(negedge clk);
      if (b == 0) check("rm_beat0", bus.data_o, 32'h00010203);
      if (b == 7) begin
        check("rm_beat7", bus.data_o, 32'h1C1D1E1F);
        check("rm_last7", bus.last_o, 1'b1);
        check("rm_ready7", bus.in_ready_o, 1'b1);
      end
      step();
    end
    check("rm_idle", bus.out_valid_o, 1'b0);

    // Column-major request (row-major output when transpose is compiled out)
    send(m0, 1'b1);
    for (int b = 0; b < NB; b++) begin
      @(negedge clk);
`ifdef MATRIX_STREAM_FLATTENER_TRANSPOSE_EN
      if (b == 0) check("cm_beat0", bus.data_o, 32'h00081018);
      if (b == 1) check("cm_beat1", bus.data_o, 32'h01091119);
      if (b == 7) check("cm_beat7", bus.data_o, 32'h070F171F);
`else
      if (b == 0) check("cm_off_beat0", bus.data_o, 32'h00010203);
      if (b == 7) check("cm_off_beat7", bus.data_o, 32'h1C1D1E1F);
`endif
      step();
    end

    // Stall 3 cycles on beat 2
    send(m0, 1'b0);
    step(); step();
    bus.out_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_data", bus.data_o, 32'h08090A0B);
      check("stall_last", bus.last_o, 1'b0);
      step();
    end
    bus.out_ready_i = 1'b1;
    repeat (NB - 2) step();

    // Back-to-back: second matrix offered during beat 7 of the first
    send(m0, 1'b0);
    repeat (NB - 1) step();
    bus.a_i = fill(8'h40); bus.col_major_i = 1'b0; bus.in_valid_i = 1'b1;
    @(negedge clk);
    check("b2b_ready", bus.in_ready_o, 1'b1);
    check("b2b_last", bus.last_o, 1'b1);
    step();
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("b2b_valid", bus.out_valid_o, 1'b1);
    check("b2b_beat0", bus.data_o, 32'h40414243);
    repeat (NB) step();

    // Reset in the middle of beat 4
    send(m0, 1'b0);
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", bus.out_valid_o, 1'b0);
    check("mrst_ready", bus.in_ready_o, 1'b1);
    step();
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); check("mrst_quiet", bus.out_valid_o, 1'b0); end
    step();
    send(m0, 1'b0);
    @(negedge clk);
    check("mrst_restart", bus.data_o, 32'h00010203);
    repeat (NB + 1) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 20000");
    $fatal(1);
  end
endmodule
